// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the boot-image loader.
//                - loader_state_t : loader FSM state encoding
//                - frame field constants (default sync byte, header length)
//                - checksum width
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Frame start marker used unless the instantiating level overrides it.
    localparam logic [7:0] c_SYNC_DEFAULT = 8'h5A;

    // Header bytes following SYNC: ADDR_LO, ADDR_HI, LEN_LO, LEN_HI.
    localparam int c_HDR_LEN = 4;

    // Running checksum is a plain mod-256 sum.
    localparam int c_CSUM_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADDR_LO = 4'd1,
        ST_ADDR_HI = 4'd2,
        ST_LEN_LO  = 4'd3,
        ST_LEN_HI  = 4'd4,
        ST_DATA    = 4'd5,
        ST_CSUM    = 4'd6,
        ST_HOLD    = 4'd7,
        ST_RUN     = 4'd8,
        ST_ERROR   = 4'd9
    } loader_state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader
//  Description : Boot-time image loader. Parses a framed byte stream
//                (SYNC, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, payload, CSUM),
//                writes the payload into system RAM and keeps the CPU in
//                reset until the checksum matches, then holds reset for
//                RST_HOLD more cycles before releasing it.
//  Ports       :
//    i_clk, i_rst_n         clock, asynchronous active-low reset
//    i_rx_data/valid        input byte stream
//    o_rx_ready             byte accepted when valid & ready
//    o_mem_we/addr/data     registered RAM write port (1-cycle latency)
//    o_cpu_rst              active-high CPU reset
//    o_done                 image loaded, CPU running
//    o_err                  checksum failure (sticky until next SYNC)
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W   = 16,
    parameter logic [7:0] SYNC     = c_SYNC_DEFAULT,
    parameter int         RST_HOLD = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data,
    output logic              o_cpu_rst,
    output logic              o_done,
    output logic              o_err
);

    localparam int                  c_HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_HOLD - 1);

    loader_state_t         r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [7:0]            r_addr_lo;
    logic [15:0]           r_len;
    logic [c_CSUM_W-1:0]   r_csum;
    logic [c_HOLD_W-1:0]   r_hold;

    logic                  w_xfer;
    logic                  w_is_sync;
    logic [15:0]           w_hdr_addr;
    logic [15:0]           w_hdr_len;

    // The only state that refuses bytes is the post-checksum reset hold.
    assign o_rx_ready = (r_state != ST_HOLD);
    assign w_xfer     = i_rx_valid & o_rx_ready;
    assign w_is_sync  = (i_rx_data == SYNC);
    assign w_hdr_addr = {i_rx_data, r_addr_lo};
    assign w_hdr_len  = {i_rx_data, r_len[7:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_addr_lo  <= '0;
            r_len      <= '0;
            r_csum     <= '0;
            r_hold     <= '0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_cpu_rst  <= 1'b1;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted payload byte.
            o_mem_we <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && w_is_sync) begin
                        r_state <= ST_ADDR_LO;
                        r_csum  <= '0;
                    end
                end

                ST_ADDR_LO: begin
                    if (w_xfer) begin
                        r_addr_lo <= i_rx_data;
                        r_csum    <= r_csum + i_rx_data;
                        r_state   <= ST_ADDR_HI;
                    end
                end

                ST_ADDR_HI: begin
                    if (w_xfer) begin
                        // Header address is always 16 bits; fit it to ADDR_W.
                        r_addr  <= ADDR_W'(w_hdr_addr);
                        r_csum  <= r_csum + i_rx_data;
                        r_state <= ST_LEN_LO;
                    end
                end

                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_len   <= {8'h00, i_rx_data};
                        r_csum  <= r_csum + i_rx_data;
                        r_state <= ST_LEN_HI;
                    end
                end

                ST_LEN_HI: begin
                    if (w_xfer) begin
                        r_len   <= w_hdr_len;
                        r_csum  <= r_csum + i_rx_data;
                        r_state <= (w_hdr_len == 16'd0) ? ST_CSUM : ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_xfer) begin
                        o_mem_we   <= 1'b1;
                        o_mem_addr <= r_addr;
                        o_mem_data <= i_rx_data;
                        r_addr     <= r_addr + ADDR_W'(1);
                        r_len      <= r_len - 16'd1;
                        r_csum     <= r_csum + i_rx_data;
                        if (r_len == 16'd1) begin
                            r_state <= ST_CSUM;
                        end
                    end
                end

                ST_CSUM: begin
                    if (w_xfer) begin
                        if (i_rx_data == r_csum) begin
                            r_state <= ST_HOLD;
                            r_hold  <= '0;
                        end else begin
                            r_state <= ST_ERROR;
                            o_err   <= 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    // Release decisions are registered so RUN shows the
                    // running outputs from its very first cycle.
                    if (r_hold == c_HOLD_LAST) begin
                        r_state   <= ST_RUN;
                        o_cpu_rst <= 1'b0;
                        o_done    <= 1'b1;
                    end else begin
                        r_hold <= r_hold + c_HOLD_W'(1);
                    end
                end

                ST_RUN, ST_ERROR: begin
                    if (w_xfer && w_is_sync) begin
                        r_state   <= ST_ADDR_LO;
                        r_csum    <= '0;
                        o_cpu_rst <= 1'b1;
                        o_done    <= 1'b0;
                        o_err     <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : rom_loader
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_loader
//  Description : Self-checking bench for rom_loader. Frames are built from
//                an address and a payload list; the expected RAM writes and
//                checksum are computed from the frame rules directly, and
//                the observed write stream is compared against them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_loader;
    import loader_pkg::*;

    localparam int         RST_HOLD = 4;
    localparam logic [7:0] SYNC     = c_SYNC_DEFAULT;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    rom_loader #(
        .ADDR_W   (16),
        .SYNC     (SYNC),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_rx_ready (rx_ready),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_data),
        .o_cpu_rst  (cpu_rst),
        .o_done     (done),
        .o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    bit          gaps  = 1'b1;
    logic [23:0] got[$];
    logic [23:0] expw[$];
    logic [7:0]  payload[$];

    // Record every RAM write as {addr, data}.
    always @(negedge clk) begin
        if (rst_n && mem_we) got.push_back({mem_addr, mem_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", (n < 64) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Sends SYNC, header, the first 'stop' payload bytes (all when stop<0)
    // and, for a complete frame, the checksum (inverted LSB when bad).
    task automatic send_frame(input logic [15:0] addr, input bit bad, input int stop);
        logic [7:0]  sum;
        logic [7:0]  hdr[4];
        logic [15:0] len;
        int          nsend;
        len    = 16'(payload.size());
        hdr[0] = addr[7:0];
        hdr[1] = addr[15:8];
        hdr[2] = len[7:0];
        hdr[3] = len[15:8];
        nsend  = (stop < 0) ? payload.size() : stop;
        sum    = 8'h00;
        send_byte(SYNC);
        @(negedge clk);
        chk("sync_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("sync_done",    {31'd0, done},    32'd0);
        chk("sync_err",     {31'd0, err},     32'd0);
        for (int i = 0; i < c_HDR_LEN; i++) begin
            sum = sum + hdr[i];
            send_byte(hdr[i]);
        end
        for (int i = 0; i < nsend; i++) begin
            sum = sum + payload[i];
            expw.push_back({addr + 16'(i), payload[i]});
            send_byte(payload[i]);
        end
        if (stop < 0) send_byte(bad ? (sum ^ 8'h01) : sum);
    endtask

    task automatic check_hold_run();
        for (int i = 0; i < RST_HOLD; i++) begin
            @(negedge clk);
            chk("hold_ready",   {31'd0, rx_ready}, 32'd0);
            chk("hold_cpu_rst", {31'd0, cpu_rst},  32'd1);
            chk("hold_done",    {31'd0, done},     32'd0);
        end
        @(negedge clk);
        chk("run_cpu_rst", {31'd0, cpu_rst},  32'd0);
        chk("run_done",    {31'd0, done},     32'd1);
        chk("run_ready",   {31'd0, rx_ready}, 32'd1);
        chk("run_err",     {31'd0, err},      32'd0);
    endtask

    task automatic check_error();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_flag",    {31'd0, err},      32'd1);
            chk("err_cpu_rst", {31'd0, cpu_rst},  32'd1);
            chk("err_done",    {31'd0, done},     32'd0);
            chk("err_ready",   {31'd0, rx_ready}, 32'd1);
        end
    endtask

    task automatic check_writes();
        int n;
        chk("write_count", got.size(), expw.size());
        n = (got.size() < expw.size()) ? got.size() : expw.size();
        for (int i = 0; i < n; i++) chk("write_addr_data", {8'd0, got[i]}, {8'd0, expw[i]});
        got.delete();
        expw.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_cpu_rst", {31'd0, cpu_rst},  32'd1);
        chk("rst_ready",   {31'd0, rx_ready}, 32'd1);
        chk("rst_we",      {31'd0, mem_we},   32'd0);
        chk("rst_done",    {31'd0, done},     32'd0);
        chk("rst_err",     {31'd0, err},      32'd0);
        chk("rst_addr",    {16'd0, mem_addr}, 32'd0);

        // Junk in IDLE is dropped.
        send_byte(8'h00);
        send_byte(8'hA5);

        // Reference frame: 3 bytes at 0x0200.
        payload = '{8'hA9, 8'h01, 8'hEA};
        send_frame(16'h0200, 1'b0, -1);
        check_hold_run();
        check_writes();

        // Junk while running changes nothing.
        send_byte(8'h13);
        @(negedge clk);
        chk("run_junk_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("run_junk_done",    {31'd0, done},    32'd1);

        // Same frame with a bad checksum (restart from RUN).
        send_frame(16'h0200, 1'b1, -1);
        check_error();
        check_writes();
        send_byte(8'h77);
        @(negedge clk);
        chk("err_junk_err", {31'd0, err}, 32'd1);

        // Address wrap at the top of memory, started from ERROR.
        payload = '{8'h11, 8'h22};
        send_frame(16'hFFFF, 1'b0, -1);
        check_hold_run();
        check_writes();

        // Empty payload.
        payload.delete();
        send_frame(16'h1234, 1'b0, -1);
        check_hold_run();
        check_writes();

        // Random frames; payload may contain the sync value.
        for (int k = 0; k < 5; k++) begin
            logic [15:0] a;
            bit          bad;
            gaps = (k != 1);
            a    = 16'($urandom);
            bad  = (k == 2);
            payload.delete();
            repeat ($urandom_range(1, 8)) payload.push_back((($urandom & 3) == 0) ? SYNC : 8'($urandom));
            send_frame(a, bad, -1);
            if (bad) check_error();
            else     check_hold_run();
            check_writes();
        end
        gaps = 1'b1;

        // Reset asserted mid-payload.
        payload = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(16'h4000, 1'b0, 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we",      {31'd0, mem_we},  32'd0);
        chk("abort_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        repeat (2) @(negedge clk);
        chk("abort_we_hold", {31'd0, mem_we},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready",   {31'd0, rx_ready}, 32'd1);
        chk("rel_cpu_rst", {31'd0, cpu_rst},  32'd1);
        chk("rel_done",    {31'd0, done},     32'd0);
        chk("rel_err",     {31'd0, err},      32'd0);
        chk("rel_addr",    {16'd0, mem_addr}, 32'd0);
        chk("rel_data",    {24'd0, mem_data}, 32'd0);
        check_writes();

        // Loader recovers from IDLE after the abort.
        send_byte(8'h03);
        payload = '{8'hDE, 8'hAD};
        send_frame(16'h8000, 1'b0, -1);
        check_hold_run();
        check_writes();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rom_loader
`default_nettype wire
